// File: rtl/replacement_pkg.sv
// Shared constants, FSM encoding and helper functions for the cache replacement engine.
// No logic of its own; imported by replacement_engine and its sub-modules.
package replacement_pkg;

    localparam int POLICY_FIFO   = 0;
    localparam int POLICY_RANDOM = 1;
    localparam int POLICY_PLRU   = 2;

    localparam int MAX_WAYS = 256;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Galois right-shift feedback masks (bit k set means tap k+1); 0 marks an unsupported width.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Lowest-index clear bit; callers pad unused positions with ones.
    function automatic logic [7:0] first_invalid(input logic [MAX_WAYS-1:0] valid);
        logic [7:0] idx;
        idx = 8'd0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) idx = 8'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lfsr.sv
// Free-running Galois LFSR, seeded with 1 on reset; exposes its low OUT_WIDTH bits.
// Latency: new value every clock. Backpressure: none, it never stalls.
module lfsr #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] TAPS      = 32'h0000_00B8,
    parameter int          OUT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [OUT_WIDTH-1:0] value
);

    logic [WIDTH-1:0] state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WIDTH'(1);
        end else begin
            state <= (state >> 1) ^ (state[0] ? TAPS[WIDTH-1:0] : '0);
        end
    end

    assign value = state[OUT_WIDTH-1:0];

endmodule

// File: rtl/plru_tree.sv
// Tree-PLRU helper: victim walk and touch update for one set's tree bits (heap order, node 0 = root).
// Latency: purely combinational. Backpressure: none.
module plru_tree #(
    parameter int  WAY_COUNT = 4,
    localparam int WW        = $clog2(WAY_COUNT)
) (
    input  logic [WAY_COUNT-2:0] tree,
    input  logic [WW-1:0]        touch_way,
    output logic [WW-1:0]        victim,
    output logic [WAY_COUNT-2:0] tree_next
);

    always_comb begin : walk
        int   node;
        logic b;
        victim = '0;
        node   = 0;
        b      = 1'b0;
        for (int lvl = 0; lvl < WW; lvl++) begin
            b      = tree[node[WW-1:0]];
            victim = WW'({victim, b});
            node   = 2 * node + 1 + int'(b);
        end
    end

    // Each node on the touched path is pointed at the opposite half.
    always_comb begin : touch
        int            node;
        logic [WW-1:0] w;
        logic          d;
        tree_next = tree;
        node      = 0;
        w         = touch_way;
        d         = 1'b0;
        for (int lvl = 0; lvl < WW; lvl++) begin
            d                         = w[WW-1];
            tree_next[node[WW-1:0]]   = ~d;
            node                      = 2 * node + 1 + int'(d);
            w                         = w << 1;
        end
    end

endmodule

// File: rtl/replacement_engine.sv
// Per-set victim selector (FIFO / random / tree-PLRU) with valid tracking and sequenced flush.
// Latency: replacement_way combinational from state; updates land on the next edge. Backpressure: ready low SET_COUNT cycles per flush.
// REPLACEMENT_EVICT_COUNT_EN adds a saturating evict_count output.
module replacement_engine
    import replacement_pkg::*;
#(
    parameter int WAY_COUNT  = 4,
    parameter int SET_COUNT  = 64,
    parameter int POLICY     = 2,
    parameter int LFSR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(SET_COUNT)-1:0] set,
    input  logic [$clog2(WAY_COUNT)-1:0] way,
    output logic [$clog2(WAY_COUNT)-1:0] replacement_way,
    input  logic                         read,
    input  logic                         written,
    input  logic                         taken,
    input  logic                         flush,
    output logic                         ready
`ifdef REPLACEMENT_EVICT_COUNT_EN
    ,
    output logic [31:0]                  evict_count
`endif
);

    localparam int WW = $clog2(WAY_COUNT);
    localparam int SW = $clog2(SET_COUNT);

    if (WAY_COUNT < 2 || WAY_COUNT > MAX_WAYS || (WAY_COUNT & (WAY_COUNT - 1)) != 0) begin : g_bad_ways
        $error("replacement_engine: WAY_COUNT must be a power of two in [2,%0d]", MAX_WAYS);
    end
    if (SET_COUNT < 2 || (SET_COUNT & (SET_COUNT - 1)) != 0) begin : g_bad_sets
        $error("replacement_engine: SET_COUNT must be a power of two >= 2");
    end
    if (POLICY < POLICY_FIFO || POLICY > POLICY_PLRU) begin : g_bad_policy
        $error("replacement_engine: POLICY must be 0, 1 or 2");
    end
    if (LFSR_WIDTH < WW || lfsr_taps(LFSR_WIDTH) == 32'h0) begin : g_bad_lfsr
        $error("replacement_engine: unsupported LFSR_WIDTH");
    end

    state_t               state;
    logic [SW-1:0]        flush_idx;
    logic [WAY_COUNT-1:0] valid_q [SET_COUNT];
    logic [WW-1:0]        fifo_q  [SET_COUNT];
    logic [WAY_COUNT-2:0] tree_q  [SET_COUNT];

    logic [WAY_COUNT-1:0] valid_cur;
    logic [MAX_WAYS-1:0]  valid_ext;
    logic                 all_valid;
    logic [WW-1:0]        first_inv;
    logic [WW-1:0]        policy_way;
    logic [WW-1:0]        plru_victim;
    logic [WW-1:0]        rnd_way;
    logic [WW-1:0]        touch_way;
    logic [WAY_COUNT-2:0] tree_next;
    logic                 accept;

    assign valid_cur = valid_q[set];
    assign all_valid = &valid_cur;

    always_comb begin
        valid_ext                = '1;
        valid_ext[WAY_COUNT-1:0] = valid_cur;
    end

    assign first_inv = WW'(first_invalid(valid_ext));

    always_comb begin
        case (POLICY)
            POLICY_FIFO:   policy_way = fifo_q[set];
            POLICY_RANDOM: policy_way = rnd_way;
            default:       policy_way = plru_victim;
        endcase
    end

    assign replacement_way = all_valid ? policy_way : first_inv;

    // A hit/fill touch of `way` takes priority over touching the consumed victim.
    assign touch_way = (read || written) ? way : replacement_way;

    plru_tree #(
        .WAY_COUNT (WAY_COUNT)
    ) u_plru (
        .tree      (tree_q[set]),
        .touch_way (touch_way),
        .victim    (plru_victim),
        .tree_next (tree_next)
    );

    lfsr #(
        .WIDTH     (LFSR_WIDTH),
        .TAPS      (lfsr_taps(LFSR_WIDTH)),
        .OUT_WIDTH (WW)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (rnd_way)
    );

    assign ready  = (state == IDLE);
    assign accept = ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            flush_idx <= '0;
            for (int s = 0; s < SET_COUNT; s++) begin
                valid_q[s] <= '0;
                fifo_q[s]  <= '0;
                tree_q[s]  <= '0;
            end
        end else if (state == FLUSH) begin
            valid_q[flush_idx] <= '0;
            fifo_q[flush_idx]  <= '0;
            tree_q[flush_idx]  <= '0;
            flush_idx          <= flush_idx + SW'(1);
            if (flush_idx == SW'(SET_COUNT - 1)) state <= IDLE;
        end else if (flush) begin
            state     <= FLUSH;
            flush_idx <= '0;
        end else begin
            if (written) valid_q[set][way] <= 1'b1;
            if (POLICY == POLICY_PLRU && (read || written || taken)) tree_q[set] <= tree_next;
            if (POLICY == POLICY_FIFO && taken && all_valid) fifo_q[set] <= fifo_q[set] + WW'(1);
        end
    end

`ifdef REPLACEMENT_EVICT_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evict_count <= '0;
        end else if (ready && flush) begin
            evict_count <= '0;
        end else if (accept && taken && all_valid && evict_count != 32'hFFFF_FFFF) begin
            evict_count <= evict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_replacement_engine.sv
// Directed bench for replacement_engine: a PLRU and a FIFO instance share one stimulus stream.
// Expected values are hand-derived per step; REPLACEMENT_EVICT_COUNT_EN adds evict_count checks.
module tb_replacement_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] set_idx;
    logic [1:0] way_idx;
    logic       read, written, taken, flush;
    logic [1:0] rw_p, rw_f;
    logic       ready_p, ready_f;
`ifdef REPLACEMENT_EVICT_COUNT_EN
    logic [31:0] evict_p, evict_f;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_p, cnt_f;

    always #5 clk = ~clk;

    replacement_engine #(.WAY_COUNT(4), .SET_COUNT(64), .POLICY(2), .LFSR_WIDTH(8)) dut_plru (
        .clk(clk), .reset(reset), .set(set_idx), .way(way_idx), .replacement_way(rw_p),
        .read(read), .written(written), .taken(taken), .flush(flush), .ready(ready_p)
`ifdef REPLACEMENT_EVICT_COUNT_EN
        , .evict_count(evict_p)
`endif
    );

    replacement_engine #(.WAY_COUNT(4), .SET_COUNT(64), .POLICY(0), .LFSR_WIDTH(8)) dut_fifo (
        .clk(clk), .reset(reset), .set(set_idx), .way(way_idx), .replacement_way(rw_f),
        .read(read), .written(written), .taken(taken), .flush(flush), .ready(ready_f)
`ifdef REPLACEMENT_EVICT_COUNT_EN
        , .evict_count(evict_f)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic t, input logic f,
                        input logic [5:0] s, input logic [1:0] wy);
        set_idx = s; way_idx = wy; read = r; written = w; taken = t; flush = f;
        @(posedge clk); #1;
        read = 1'b0; written = 1'b0; taken = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!(ready_p && ready_f) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {30'd0, ready_p, ready_f}, 32'd3);
    endtask

    initial begin
        reset = 1'b1; set_idx = '0; way_idx = '0;
        read = 1'b0; written = 1'b0; taken = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset ready plru", ready_p, 1);
        chk("reset ready fifo", ready_f, 1);
        chk("reset way plru", rw_p, 0);
        chk("reset way fifo", rw_f, 0);
`ifdef REPLACEMENT_EVICT_COUNT_EN
        chk("reset evict", evict_p, 0);
`endif

        // Fill set 5: lowest invalid way is offered until the set is full.
        step(0, 1, 0, 0, 5, 0); chk("fill0 plru", rw_p, 1); chk("fill0 fifo", rw_f, 1);
        step(0, 1, 0, 0, 5, 1); chk("fill1 plru", rw_p, 2); chk("fill1 fifo", rw_f, 2);
        step(0, 1, 0, 0, 5, 2); chk("fill2 plru", rw_p, 3); chk("fill2 fifo", rw_f, 3);
        step(0, 1, 0, 0, 5, 3); chk("fill3 plru", rw_p, 0); chk("fill3 fifo", rw_f, 0);

        // PLRU ordering on the full set.
        step(1, 0, 0, 0, 5, 0);
        step(1, 0, 0, 0, 5, 1);
        step(1, 0, 0, 0, 5, 2);
        step(1, 0, 0, 0, 5, 3); chk("plru read0123", rw_p, 0);
        step(1, 0, 0, 0, 5, 0); chk("plru read0 again", rw_p, 2); chk("fifo read no-op", rw_f, 0);
        step(0, 0, 1, 0, 5, 0); chk("plru taken touch", rw_p, 1); chk("fifo taken set5", rw_f, 1);
        step(1, 0, 1, 0, 5, 2); chk("plru read overrides taken", rw_p, 1); chk("fifo taken+read", rw_f, 2);

        // FIFO wrap on set 7, with set 8 full but untouched.
        for (int w = 0; w < 4; w++) step(0, 1, 0, 0, 8, 2'(w));
        for (int w = 0; w < 4; w++) step(0, 1, 0, 0, 7, 2'(w));
        chk("fifo set7 full", rw_f, 0);
        step(0, 0, 1, 0, 7, 0); chk("fifo wrap 1", rw_f, 1);
        step(0, 0, 1, 0, 7, 0); chk("fifo wrap 2", rw_f, 2);
        step(0, 0, 1, 0, 7, 0); chk("fifo wrap 3", rw_f, 3);
        step(0, 0, 1, 0, 7, 0); chk("fifo wrap 0", rw_f, 0);
        step(0, 0, 1, 0, 7, 0); chk("fifo wrap 1b", rw_f, 1);
        set_idx = 8; #1; chk("fifo set8 untouched", rw_f, 0);

        // taken on a not-full set must not advance the FIFO counter.
        step(0, 1, 0, 0, 9, 0); chk("fifo set9 partial", rw_f, 1);
        step(0, 0, 1, 0, 9, 0); chk("fifo set9 taken partial", rw_f, 1);
        for (int w = 1; w < 4; w++) step(0, 1, 0, 0, 9, 2'(w));
        chk("fifo set9 counter held", rw_f, 0);
`ifdef REPLACEMENT_EVICT_COUNT_EN
        chk("evict before flush plru", evict_p, 7);
        chk("evict before flush fifo", evict_f, 7);
`endif

        // Flush with a concurrent taken; further requests mid-flush are ignored.
        step(0, 0, 1, 1, 7, 0);
        chk("flush ready drops", ready_p, 0);
`ifdef REPLACEMENT_EVICT_COUNT_EN
        chk("flush clears evict", evict_p, 0);
`endif
        cnt_p = 0; cnt_f = 0;
        for (int i = 0; i < 200 && !(ready_p && ready_f); i++) begin
            if (!ready_p) cnt_p++;
            if (!ready_f) cnt_f++;
            if (i == 30) begin
                set_idx = 0; way_idx = 0; read = 1'b1; written = 1'b1; taken = 1'b1;
            end
            @(posedge clk); #1;
            read = 1'b0; written = 1'b0; taken = 1'b0;
        end
        chk("flush ready-low plru", cnt_p, 64);
        chk("flush ready-low fifo", cnt_f, 64);
        for (int s = 0; s < 64; s++) begin
            set_idx = 6'(s); #1;
            chk($sformatf("post-flush plru set%0d", s), rw_p, 0);
            chk($sformatf("post-flush fifo set%0d", s), rw_f, 0);
        end
        step(0, 1, 0, 0, 7, 0); chk("post-flush invalid plru", rw_p, 1); chk("post-flush invalid fifo", rw_f, 1);

        // Reset in the middle of a flush.
        step(0, 1, 0, 0, 40, 0); chk("set40 fill plru", rw_p, 1);
        step(0, 0, 0, 1, 40, 0);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        #2 chk("reset mid-flush async ready", ready_p, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("after reset ready plru", ready_p, 1);
        chk("after reset ready fifo", ready_f, 1);
        set_idx = 40; #1;
        chk("after reset set40 plru", rw_p, 0);
        chk("after reset set40 fifo", rw_f, 0);
        repeat (3) @(posedge clk);
        #1 chk("flush not resumed", {ready_p, ready_f}, 2'b11);

`ifdef REPLACEMENT_EVICT_COUNT_EN
        chk("after reset evict", evict_p, 0);
        for (int w = 0; w < 4; w++) step(0, 1, 0, 0, 3, 2'(w));
        step(0, 0, 1, 0, 3, 0);
        step(0, 0, 1, 0, 3, 0);
        step(0, 0, 1, 0, 3, 0);
        chk("evict 3 plru", evict_p, 3);
        chk("evict 3 fifo", evict_f, 3);
        step(0, 0, 0, 1, 3, 0);
        chk("evict flush clear", evict_f, 0);
        wait_ready("final flush completes");
`else
        step(0, 0, 0, 1, 3, 0);
        wait_ready("final flush completes");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
